// File: rtl/ram16_streamer_pkg.sv
// Shared constants and types for the ram16 sequencing master.
// The memory geometry and the controller state encoding live here so bench and RTL agree.
package ram16_streamer_pkg;

    localparam int RAM16_AW    = 4;
    localparam int RAM16_DW    = 16;
    localparam int RAM16_DEPTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DUMP = 2'd2
    } state_t;

    // A window can never be larger than the memory itself.
    function automatic logic [4:0] clamp_count(input logic [4:0] c);
        return (c > 5'(RAM16_DEPTH)) ? 5'(RAM16_DEPTH) : c;
    endfunction

endpackage

// File: rtl/ram16_streamer.sv
// Sequencing master for a 16x16 ram16: fills an address window from a valid/ready
// stream, or dumps a window onto a registered valid/ready output stream.
module ram16_streamer
    import ram16_streamer_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                mode,
    input  logic [RAM16_AW-1:0] base,
    input  logic [4:0]          count,
    output logic                busy,
    output logic                done,
    input  logic [RAM16_DW-1:0] s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic [RAM16_DW-1:0] m_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [RAM16_AW-1:0] mem_address,
    output logic [RAM16_DW-1:0] mem_in,
    output logic                mem_load,
    input  logic [RAM16_DW-1:0] mem_out
);

    state_t                state_q;
    logic [RAM16_AW-1:0]   ptr_q;
    logic [4:0]            remaining_q;
    logic [RAM16_DW-1:0]   m_data_q;
    logic                  m_valid_q;
    logic                  done_q;

    logic dump_adv;
    logic dump_end;

    // The output slot may be refilled when empty or when its word leaves this edge.
    assign dump_adv = (state_q == ST_DUMP) && (!m_valid_q || m_ready) && (remaining_q != 5'd0);
    assign dump_end = (state_q == ST_DUMP) && m_valid_q && m_ready && (remaining_q == 5'd0);

    // NOTE: non-blocking assignments keep every register update on the same edge snapshot.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (count == 5'd0) begin
                            done_q <= 1'b1;
                        end else begin
                            ptr_q       <= base;
                            remaining_q <= clamp_count(count);
                            state_q     <= mode ? ST_DUMP : ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    if (s_valid) begin
                        ptr_q       <= ptr_q + 4'd1;
                        remaining_q <= remaining_q - 5'd1;
                        if (remaining_q == 5'd1) begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_DUMP: begin
                    if (dump_end) begin
                        m_valid_q <= 1'b0;
                        state_q   <= ST_IDLE;
                        done_q    <= 1'b1;
                    end else if (dump_adv) begin
                        m_data_q    <= mem_out;
                        m_valid_q   <= 1'b1;
                        ptr_q       <= ptr_q + 4'd1;
                        remaining_q <= remaining_q - 5'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Fill-side memory pins are combinational so the write lands on the handshake edge.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        s_ready     = 1'b0;
        mem_load    = 1'b0;
        mem_address = '0;
        mem_in      = '0;
        if (state_q == ST_FILL) begin
            s_ready     = 1'b1;
            mem_load    = s_valid;
            mem_address = ptr_q;
            mem_in      = s_data;
        end else if (state_q == ST_DUMP) begin
            mem_address = ptr_q;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;

endmodule
